// File: rtl/nand_init_sequencer_if.sv
// Command handshake between the NAND init sequencer (master) and the NAND PHY (slave).
interface nand_init_sequencer_if #(
  parameter int NUM_CE = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_opcode;
  logic [NUM_CE-1:0] cmd_ce;

  modport master (output cmd_valid, output cmd_opcode, output cmd_ce, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_opcode, input cmd_ce, output cmd_ready);
endinterface

// File: rtl/nand_init_sequencer.sv
// Power-up sequencer: waits for IDELAY ready and tPOR, then issues RESET to each
// NAND chip enable in turn and waits for that target's R/B# to return ready.
module nand_init_sequencer #(
  parameter int         NUM_CE         = 4,
  parameter int         TPOR_CYCLES    = 10000,
  parameter int         TWB_CYCLES     = 10,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] RST_OPCODE     = 8'hFF,
  localparam int        IDX_W          = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  idelay_rdy,
  input  logic [NUM_CE-1:0]     rb_n,
  input  logic                  restart,
  nand_init_sequencer_if.master cmd,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [IDX_W-1:0]      err_ce
);

  localparam int MAX_A   = (TPOR_CYCLES > TWB_CYCLES) ? TPOR_CYCLES : TWB_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [NUM_CE-1:0] CE_ONE = NUM_CE'(1);

  typedef enum logic [2:0] {
    S_WAIT_RDY, S_WAIT_POR, S_ISSUE, S_WAIT_WB, S_WAIT_RB, S_DONE, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ce_idx_q, ce_idx_d;
  logic [IDX_W-1:0]  err_ce_q, err_ce_d;
  logic [1:0]        rdy_sync_q;
  logic [NUM_CE-1:0] rb_meta_q, rb_sync_q;
  logic              cmd_valid_q, busy_q, init_done_q, init_err_q;
  logic [7:0]        cmd_opcode_q;
  logic [NUM_CE-1:0] cmd_ce_q;
  logic              rb_sel;

  assign rb_sel = rb_sync_q[ce_idx_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ce_idx_d = ce_idx_q;
    err_ce_d = err_ce_q;
    unique case (state_q)
      S_WAIT_RDY: begin
        if (rdy_sync_q[1]) begin
          state_d = S_WAIT_POR;
          cnt_d   = CNT_W'(TPOR_CYCLES);
        end
      end
      S_WAIT_POR: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end
      end
      // No timeout on cmd_ready: the PHY is trusted to eventually accept.
      S_ISSUE: begin
        if (cmd_ready_i_acc()) begin
          state_d = S_WAIT_WB;
          cnt_d   = CNT_W'(TWB_CYCLES);
        end
      end
      S_WAIT_WB: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_WAIT_RB;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
        end
      end
      // Ready is tested before the timeout so a last-cycle R/B# rise still succeeds.
      S_WAIT_RB: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (rb_sel) begin
          cnt_d = '0;
          if (ce_idx_q == IDX_W'(NUM_CE - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ISSUE;
            ce_idx_d = ce_idx_q + IDX_W'(1);
          end
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = S_ERROR;
          cnt_d    = '0;
          err_ce_d = ce_idx_q;
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          state_d  = S_WAIT_RDY;
          ce_idx_d = '0;
        end
      end
      default: begin
        state_d = S_WAIT_RDY;
        cnt_d   = '0;
      end
    endcase
  end

  function automatic logic cmd_ready_i_acc();
    return cmd_valid_q && cmd.cmd_ready;
  endfunction

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q      <= S_WAIT_RDY;
      cnt_q        <= '0;
      ce_idx_q     <= '0;
      err_ce_q     <= '0;
      rdy_sync_q   <= '0;
      rb_meta_q    <= '0;
      rb_sync_q    <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= 8'h00;
      cmd_ce_q     <= '0;
      busy_q       <= 1'b1;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ce_idx_q     <= ce_idx_d;
      err_ce_q     <= err_ce_d;
      rdy_sync_q   <= {rdy_sync_q[0], idelay_rdy};
      rb_meta_q    <= rb_n;
      rb_sync_q    <= rb_meta_q;
      // Outputs are registered from the next state so they line up with state_q.
      cmd_valid_q  <= (state_d == S_ISSUE);
      cmd_opcode_q <= (state_d == S_ISSUE) ? RST_OPCODE : 8'h00;
      cmd_ce_q     <= (state_d == S_ISSUE) ? (CE_ONE << ce_idx_d) : '0;
      busy_q       <= (state_d != S_DONE) && (state_d != S_ERROR);
      init_done_q  <= (state_d == S_DONE);
      init_err_q   <= (state_d == S_ERROR);
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_opcode = cmd_opcode_q;
  assign cmd.cmd_ce     = cmd_ce_q;
  assign busy           = busy_q;
  assign init_done      = init_done_q;
  assign init_err       = init_err_q;
  assign err_ce         = err_ce_q;

endmodule
